sdr_arbiter: RTL and testbench
==============================

Name: sdr_arbiter

Overview:
- Round-robin arbiter that shares one avalon_sdr SDRAM bridge among NREQ requesters (for example the ray loader, the triangle fetcher and the pixel writer).
- Accepts one read or write job per requester, latches its parameters and drives the bridge's start/end handshake.
- Broadcasts read data to all requesters and returns a per-requester done/error pulse.
- Sits between the compute blocks and the avalon_sdr instance, in the same clock domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_NREAD, 64, max 32-bit words per read job; must match the bridge.
- MAX_NWRITE, 64, max 32-bit words per write job; must match the bridge.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester job request, level; held until that requester's req_done.
- req_write  in  NREQ  1 = write job, 0 = read job.
- req_baseaddr  in  32*NREQ  byte base address, slice i = requester i.
- req_nelems  in  30*NREQ  32-bit word count, slice i.
- req_writedata  in  32*MAX_NWRITE*NREQ  write payload, slice i.
- req_done  out  NREQ  one-cycle completion pulse.
- req_err  out  NREQ  one-cycle pulse, coincident with req_done, when the job is rejected.
- rsp_readdata  out  32*MAX_NREAD  captured data of the last completed read, shared by all requesters.
- grant_id  out  $clog2(NREQ)  index of the owning/last-served requester.
- busy  out  1  high when not in IDLE.
- sdr_baseaddr  out  32  to bridge.
- sdr_nelems  out  30  to bridge.
- sdr_writedata  out  32*MAX_NWRITE  to bridge.
- sdr_readstart  out  1  to bridge.
- sdr_writestart  out  1  to bridge.
- sdr_readdata  in  32*MAX_NREAD  from bridge.
- sdr_readend  in  1  from bridge, one-cycle pulse.
- sdr_writeend  in  1  from bridge, one-cycle pulse.

Behaviour:
- Reset, synchronous: state = IDLE; all outputs 0, including rsp_readdata, grant_id, busy, sdr_* and req_done/req_err. The round-robin pointer is set so requester 0 has top priority. Reset mid-job aborts the job with no done pulse. The bridge shares the same reset.
- States and transitions:
  - IDLE: if any req_valid is high, pick the first set bit scanning from (last+1) mod NREQ upward with wrap. Register grant_id, req_write, baseaddr and nelems; the writedata slice is registered into sdr_writedata. Go to CHECK.
  - CHECK: if nelems == 0, or nelems > MAX_NREAD on a read, or nelems > MAX_NWRITE on a write, go to DONE with error flagged and no bridge access. Otherwise go to ISSUE.
  - ISSUE: for exactly one cycle, sdr_writestart = 1 for a write or sdr_readstart = 1 for a read, never both. Go to BUSY.
  - BUSY: wait for the end pulse that matches the job type. Ignore the non-matching end pulse. On sdr_readend, capture sdr_readdata into rsp_readdata in the same edge. Go to DONE.
  - DONE: req_done[grant_id] = 1 for one cycle, req_err[grant_id] = error flag. Update last = grant_id. Go to IDLE.
- Latency:
  - req_valid sampled at edge 0 (IDLE) gives start high in cycle 2 (after CHECK).
  - req_done rises 1 cycle after the bridge's end pulse.
  - Minimum turnaround between jobs is 1 IDLE cycle.
- Registered bridge inputs: sdr_baseaddr, sdr_nelems and sdr_writedata are registered and stay stable from CHECK through DONE. Requester inputs may change once the job is granted.
- Requester holding req_valid: a requester must drop req_valid in the cycle after its req_done. If req_valid is still high when IDLE is next entered, that is a new job.
- Requests arriving during a job wait, with no loss. Fairness: a continuously requesting requester is served at most once per NREQ jobs while others are pending.
- rsp_readdata changes only on a successful read's end pulse. Write and error jobs leave it unchanged.
- busy = (state != IDLE).
- An end pulse in IDLE, CHECK, ISSUE or DONE is ignored.

Test Plan:
- Single read: requester 0 reads baseaddr 0x1000, nelems 4, and the bridge model returns words 0xA0..0xA3. Required: one sdr_readstart pulse with sdr_baseaddr = 0x1000 and sdr_nelems = 4; req_done[0] 1 cycle after sdr_readend; rsp_readdata[127:0] = {A3,A2,A1,A0}; req_err = 0.
- Contention: req_valid = 2'b11 in the same cycle, both writes. Required: requester 0 is served first, then requester 1, with exactly one start per job and no overlap. With both held high, the next grant order is 0, 1, 0, 1.
- Rejection: nelems = 0, then read nelems = 65 with MAX_NREAD = 64. Required: req_done and req_err pulse together 2 cycles after the request; no sdr_*start pulse; rsp_readdata unchanged.
- Stray end pulse: sdr_writeend pulses during a read job. Required: the job stays in BUSY; done occurs only on sdr_readend.
- Reset mid-job: reset is asserted in BUSY. Required: next cycle busy = 0, all outputs 0, no req_done. A request after reset is granted to requester 0 first.
- Register stability: requester 1 changes req_baseaddr right after grant. Required: sdr_baseaddr holds the granted value until DONE.

Source files
------------

// File: rtl/sdr_arbiter.sv
// sdr_arbiter: round-robin arbiter sharing one avalon_sdr bridge among NREQ job requesters.
module sdr_arbiter #(
    parameter int NREQ       = 2,
    parameter int MAX_NREAD  = 64,
    parameter int MAX_NWRITE = 64,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_write,
    input  logic [32*NREQ-1:0]            req_baseaddr,
    input  logic [30*NREQ-1:0]            req_nelems,
    input  logic [32*MAX_NWRITE*NREQ-1:0] req_writedata,
    output logic [NREQ-1:0]               req_done,
    output logic [NREQ-1:0]               req_err,
    output logic [32*MAX_NREAD-1:0]       rsp_readdata,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic [31:0]                   sdr_baseaddr,
    output logic [29:0]                   sdr_nelems,
    output logic [32*MAX_NWRITE-1:0]      sdr_writedata,
    output logic                          sdr_readstart,
    output logic                          sdr_writestart,
    input  logic [32*MAX_NREAD-1:0]       sdr_readdata,
    input  logic                          sdr_readend,
    input  logic                          sdr_writeend
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, BUSY, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] last, sel, idx;
    logic          found, wr, err, bad;

    // scan from last+1 upward with wrap; first set request wins
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = last;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign bad = (sdr_nelems == '0) || (sdr_nelems > (wr ? 30'(MAX_NWRITE) : 30'(MAX_NREAD)));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? CHECK : IDLE;
            CHECK:   state_n = bad ? DONE : ISSUE;
            ISSUE:   state_n = BUSY;
            BUSY:    state_n = (wr ? sdr_writeend : sdr_readend) ? DONE : BUSY;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last          <= IW'(NREQ-1);
            grant_id      <= '0;
            wr            <= 1'b0;
            err           <= 1'b0;
            sdr_baseaddr  <= '0;
            sdr_nelems    <= '0;
            sdr_writedata <= '0;
            rsp_readdata  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                grant_id      <= sel;
                wr            <= req_write[sel];
                sdr_baseaddr  <= req_baseaddr[32*sel +: 32];
                sdr_nelems    <= req_nelems[30*sel +: 30];
                sdr_writedata <= req_writedata[32*MAX_NWRITE*sel +: 32*MAX_NWRITE];
            end
            if (state == CHECK)
                err <= bad;
            if (state == BUSY && !wr && sdr_readend)
                rsp_readdata <= sdr_readdata;
            if (state == DONE)
                last <= grant_id;
        end
    end

    assign busy           = (state != IDLE);
    assign sdr_readstart  = (state == ISSUE) && !wr;
    assign sdr_writestart = (state == ISSUE) && wr;
    assign req_done       = (state == DONE) ? (NREQ'(1) << grant_id) : '0;
    assign req_err        = err ? req_done : '0;
endmodule

// File: tb/tb_sdr_arbiter.sv
// tb_sdr_arbiter: directed scenario tests of sdr_arbiter with a hand-driven bridge.
module tb_sdr_arbiter;
    localparam int NREQ = 2;
    localparam int MR   = 64;
    localparam int MW   = 64;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NREQ-1:0]          req_valid, req_write, req_done, req_err;
    logic [32*NREQ-1:0]       req_baseaddr;
    logic [30*NREQ-1:0]       req_nelems;
    logic [32*MW*NREQ-1:0]    req_writedata;
    logic [32*MR-1:0]         rsp_readdata, sdr_readdata;
    logic [0:0]               grant_id;
    logic                     busy, sdr_readstart, sdr_writestart, sdr_readend, sdr_writeend;
    logic [31:0]              sdr_baseaddr;
    logic [29:0]              sdr_nelems;
    logic [32*MW-1:0]         sdr_writedata;

    int n_checks = 0, n_fail = 0;
    int rs_cnt = 0, ws_cnt = 0, both_cnt = 0;

    sdr_arbiter #(.NREQ(NREQ), .MAX_NREAD(MR), .MAX_NWRITE(MW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_baseaddr(req_baseaddr),
        .req_nelems(req_nelems), .req_writedata(req_writedata),
        .req_done(req_done), .req_err(req_err), .rsp_readdata(rsp_readdata),
        .grant_id(grant_id), .busy(busy),
        .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
        .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
        .sdr_readdata(sdr_readdata), .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sdr_readstart) rs_cnt <= rs_cnt + 1;
        if (sdr_writestart) ws_cnt <= ws_cnt + 1;
        if (sdr_readstart && sdr_writestart) both_cnt <= both_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int i, input bit w, input logic [31:0] a, input logic [29:0] n);
        req_write[i] = w;
        req_baseaddr[32*i +: 32] = a;
        req_nelems[30*i +: 30] = n;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0;
        sdr_readend = 1'b0;
        sdr_writeend = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        n_checks++;
        if (busy !== 1'b0 || req_done !== '0 || req_err !== '0 || grant_id !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b err=%b gid=%b want all 0", busy, req_done, req_err, grant_id);
        end
        n_checks++;
        if (sdr_readstart !== 1'b0 || sdr_writestart !== 1'b0 || sdr_baseaddr !== '0 || sdr_nelems !== '0) begin
            n_fail++;
            $display("FAIL reset_sdr: rs=%b ws=%b addr=%h n=%0d want 0", sdr_readstart, sdr_writestart, sdr_baseaddr, sdr_nelems);
        end
        n_checks++;
        if (rsp_readdata !== '0 || sdr_writedata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rsp[31:0]=%h wd[31:0]=%h want 0", rsp_readdata[31:0], sdr_writedata[31:0]);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        int r0 = rs_cnt;
        set_job(0, 1'b0, 32'h1000, 30'd4);
        req_valid = 2'b01;
        tick;
        n_checks++;
        if (sdr_baseaddr !== 32'h1000 || sdr_nelems !== 30'd4 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL read_params: addr=%h n=%0d gid=%b want 1000/4/0", sdr_baseaddr, sdr_nelems, grant_id);
        end
        tick;
        n_checks++;
        if (sdr_readstart !== 1'b1 || sdr_writestart !== 1'b0) begin
            n_fail++;
            $display("FAIL read_start: rs=%b ws=%b want 1/0", sdr_readstart, sdr_writestart);
        end
        tick;
        for (int j = 0; j < 4; j++) sdr_readdata[32*j +: 32] = 32'hA0 + j;
        sdr_readend = 1'b1;
        tick;
        sdr_readend = 1'b0;
        req_valid = '0;
        n_checks++;
        if (req_done !== 2'b01 || req_err !== 2'b00) begin
            n_fail++;
            $display("FAIL read_done: done=%b err=%b want 01/00", req_done, req_err);
        end
        n_checks++;
        if (rsp_readdata[127:0] !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            n_fail++;
            $display("FAIL read_data: got %h want a3a2a1a0 words", rsp_readdata[127:0]);
        end
        tick;
        n_checks++;
        if (busy !== 1'b0 || req_done !== '0 || rs_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL read_after: busy=%b done=%b starts=%0d want 0/0/1", busy, req_done, rs_cnt - r0);
        end
    endtask

    task automatic test_reject;
        int s0 = rs_cnt + ws_cnt;
        set_job(0, 1'b0, 32'h5000, 30'd0);
        req_valid = 2'b01;
        tick;
        n_checks++;
        if (req_done !== '0) begin
            n_fail++;
            $display("FAIL rej0_early: done=%b want 00", req_done);
        end
        tick;
        req_valid = '0;
        n_checks++;
        if (req_done !== 2'b01 || req_err !== 2'b01) begin
            n_fail++;
            $display("FAIL rej0: done=%b err=%b want 01/01", req_done, req_err);
        end
        tick;
        set_job(1, 1'b0, 32'h6000, 30'd65);
        req_valid = 2'b10;
        tick;
        tick;
        req_valid = '0;
        n_checks++;
        if (req_done !== 2'b10 || req_err !== 2'b10) begin
            n_fail++;
            $display("FAIL rej65: done=%b err=%b want 10/10", req_done, req_err);
        end
        tick;
        n_checks++;
        if (rs_cnt + ws_cnt !== s0 || rsp_readdata[127:0] !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            n_fail++;
            $display("FAIL rej_side: starts=%0d rsp=%h want 0 starts, a3..a0", rs_cnt + ws_cnt - s0, rsp_readdata[127:0]);
        end
        set_job(0, 1'b1, 32'h7000, 30'd64);
        req_valid = 2'b01;
        tick;
        tick;
        n_checks++;
        if (sdr_writestart !== 1'b1 || sdr_nelems !== 30'd64) begin
            n_fail++;
            $display("FAIL max_write: ws=%b n=%0d want 1/64", sdr_writestart, sdr_nelems);
        end
        tick;
        sdr_writeend = 1'b1;
        tick;
        sdr_writeend = 1'b0;
        req_valid = '0;
        n_checks++;
        if (req_done !== 2'b01 || req_err !== 2'b00) begin
            n_fail++;
            $display("FAIL max_write_done: done=%b err=%b want 01/00", req_done, req_err);
        end
        tick;
    endtask

    task automatic test_contention;
        int w0;
        do_reset;
        w0 = ws_cnt;
        set_job(0, 1'b1, 32'h2000, 30'd2);
        set_job(1, 1'b1, 32'h3000, 30'd3);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int e = k % 2;
            int t = 0;
            while (sdr_writestart !== 1'b1 && t < 10) begin
                tick;
                t++;
            end
            n_checks++;
            if (t >= 10 || grant_id !== 1'(e) || sdr_baseaddr !== (e == 1 ? 32'h3000 : 32'h2000)
                || sdr_writedata[31:0] !== {8'(e + 1), 24'd0}) begin
                n_fail++;
                $display("FAIL grant_%0d: gid=%b addr=%h wd=%h waited=%0d want gid %0d", k, grant_id, sdr_baseaddr, sdr_writedata[31:0], t, e);
            end
            tick;
            sdr_writeend = 1'b1;
            tick;
            sdr_writeend = 1'b0;
            if (k == 3) req_valid = '0;
            n_checks++;
            if (req_done !== (2'b01 << e)) begin
                n_fail++;
                $display("FAIL done_%0d: done=%b want %b", k, req_done, 2'b01 << e);
            end
        end
        tick;
        n_checks++;
        if (ws_cnt - w0 !== 4 || both_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_starts: starts=%0d both=%0d busy=%b want 4/0/0", ws_cnt - w0, both_cnt, busy);
        end
    endtask

    task automatic test_stray;
        set_job(0, 1'b0, 32'h8000, 30'd1);
        req_valid = 2'b01;
        tick;
        tick;
        tick;
        sdr_writeend = 1'b1;
        tick;
        sdr_writeend = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || req_done !== '0) begin
            n_fail++;
            $display("FAIL stray_end: busy=%b done=%b want 1/00", busy, req_done);
        end
        tick;
        sdr_readdata[31:0] = 32'h55;
        sdr_readend = 1'b1;
        tick;
        sdr_readend = 1'b0;
        req_valid = '0;
        n_checks++;
        if (req_done !== 2'b01 || rsp_readdata[31:0] !== 32'h55) begin
            n_fail++;
            $display("FAIL stray_done: done=%b rsp=%h want 01/55", req_done, rsp_readdata[31:0]);
        end
        tick;
    endtask

    task automatic test_reset_midjob;
        set_job(1, 1'b0, 32'h9000, 30'd2);
        req_valid = 2'b10;
        tick;
        n_checks++;
        if (grant_id !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grant: gid=%b want 1", grant_id);
        end
        tick;
        tick;
        reset = 1'b1;
        req_valid = '0;
        tick;
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || grant_id !== '0 || sdr_baseaddr !== '0 || sdr_nelems !== '0
            || rsp_readdata !== '0 || req_done !== '0 || sdr_readstart !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b gid=%b addr=%h n=%0d done=%b want all 0", busy, grant_id, sdr_baseaddr, sdr_nelems, req_done);
        end
        tick;
        tick;
        n_checks++;
        if (req_done !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_nodone: done=%b busy=%b want 00/0", req_done, busy);
        end
        set_job(0, 1'b0, 32'hA000, 30'd1);
        set_job(1, 1'b0, 32'hB000, 30'd1);
        req_valid = 2'b11;
        tick;
        n_checks++;
        if (grant_id !== 1'b0 || sdr_baseaddr !== 32'hA000) begin
            n_fail++;
            $display("FAIL mid_regrant: gid=%b addr=%h want 0/a000", grant_id, sdr_baseaddr);
        end
        tick;
        tick;
        sdr_readend = 1'b1;
        tick;
        sdr_readend = 1'b0;
        req_valid = '0;
        tick;
    endtask

    task automatic test_stability;
        do_reset;
        set_job(1, 1'b1, 32'h4000, 30'd2);
        req_valid = 2'b10;
        tick;
        set_job(1, 1'b1, 32'hDEAD0000, 30'd7);
        tick;
        n_checks++;
        if (sdr_writestart !== 1'b1 || sdr_baseaddr !== 32'h4000 || sdr_nelems !== 30'd2) begin
            n_fail++;
            $display("FAIL stab_issue: ws=%b addr=%h n=%0d want 1/4000/2", sdr_writestart, sdr_baseaddr, sdr_nelems);
        end
        tick;
        n_checks++;
        if (sdr_baseaddr !== 32'h4000) begin
            n_fail++;
            $display("FAIL stab_busy: addr=%h want 4000", sdr_baseaddr);
        end
        sdr_writeend = 1'b1;
        tick;
        sdr_writeend = 1'b0;
        req_valid = '0;
        n_checks++;
        if (sdr_baseaddr !== 32'h4000 || req_done !== 2'b10) begin
            n_fail++;
            $display("FAIL stab_done: addr=%h done=%b want 4000/10", sdr_baseaddr, req_done);
        end
        tick;
    endtask

    initial begin
        req_valid = '0;
        req_write = '0;
        req_baseaddr = '0;
        req_nelems = '0;
        sdr_readdata = '0;
        sdr_readend = 1'b0;
        sdr_writeend = 1'b0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < MW; j++)
                req_writedata[32*(MW*i + j) +: 32] = {8'(i + 1), 24'(j)};
        test_reset;
        test_single_read;
        test_reject;
        test_contention;
        test_stray;
        test_reset_midjob;
        test_stability;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
